// File: rtl/bc_fir_sym_serial.sv
// ---------------------------------------------------------------------------
// bc_fir_sym_serial
//
// Symmetric unsigned binary FIR with a private sample delay line and a
// runtime-loadable coefficient bank. Each accepted sample is processed by a
// single time-multiplexed multiplier over the H = (TAPS+1)/2 folded taps.
// The result is then scaled by SHIFT and presented with a one-cycle strobe.
//
// Ports
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : in_data carries a sample
//   in_ready   : block is idle and can take a sample (registered)
//   in_data    : input sample, WIDTH bits unsigned
//   coef_we    : coefficient write strobe (honoured only while idle)
//   coef_addr  : coefficient index 0..H-1, H-1 is the centre tap
//   coef_data  : coefficient value, COEF_W bits unsigned
//   out_valid  : one-cycle strobe, out_data is new
//   out_data   : filtered sample, held until the next strobe
//
// Build option
//   BC_FIR_SAT_EN : when defined, the scaled output saturates to all ones.
//                   When undefined, it keeps the low WIDTH bits (modulo wrap).
//
// Latency: accept on edge E0, MAC over cycles 1..H, out_valid in cycle H+1,
// in_ready back in cycle H+2.
// ---------------------------------------------------------------------------
module bc_fir_sym_serial #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned TAPS   = 39,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned SHIFT  = 12,
    parameter int unsigned ACC_W  = WIDTH + 1 + COEF_W + $clog2((TAPS + 1) / 2)
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_data,
    input  logic                                 coef_we,
    input  logic [$clog2((TAPS + 1) / 2)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]                    coef_data,
    output logic                                 out_valid,
    output logic [WIDTH-1:0]                     out_data
);

    localparam int unsigned H      = (TAPS + 1) / 2;
    localparam int unsigned AW     = $clog2(H);
    localparam int unsigned XW     = $clog2(TAPS);
    localparam int unsigned PRE_W  = WIDTH + 1;
    localparam int unsigned PROD_W = PRE_W + COEF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [AW-1:0]                 k_q, k_d;
    logic [ACC_W-1:0]              acc_q, acc_d;
    logic [TAPS-1:0][WIDTH-1:0]    x_q, x_d;
    logic [H-1:0][COEF_W-1:0]      c_q, c_d;
    logic                          in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d;
    logic [WIDTH-1:0]              out_data_q, out_data_d;

    logic [XW-1:0]                 lo_idx;
    logic [XW-1:0]                 hi_idx;
    logic                          centre;
    logic [PRE_W-1:0]              pre_add;
    logic [PROD_W-1:0]             term;
    logic [ACC_W-1:0]              acc_sum;

    // Scale the accumulator down to the output width.
    function automatic logic [WIDTH-1:0] scale(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> SHIFT;
`ifdef BC_FIR_SAT_EN
        if (s > ACC_W'({WIDTH{1'b1}})) begin
            return {WIDTH{1'b1}};
        end
        return WIDTH'(s);
`else
        return WIDTH'(s);
`endif
    endfunction

    // Folded tap pair for the current k; the centre tap has no partner.
    assign lo_idx = XW'(k_q);
    assign hi_idx = XW'(TAPS - 1) - XW'(k_q);
    assign centre = (k_q == AW'(H - 1));

    always_comb begin
        pre_add = '0;
        if (centre) begin
            pre_add = {1'b0, x_q[lo_idx]};
        end else begin
            pre_add = PRE_W'(x_q[lo_idx]) + PRE_W'(x_q[hi_idx]);
        end
    end

    // Single shared multiplier and accumulate.
    assign term    = PROD_W'(pre_add) * PROD_W'(c_q[k_q]);
    assign acc_sum = acc_q + ACC_W'(term);

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            c_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            c_q         <= c_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        x_d         = x_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        case (state_q)
            S_IDLE: begin
                // Write lands before the MAC reads it, so a same-cycle
                // accept already uses the new coefficient.
                if (coef_we && (32'(coef_addr) < H)) begin
                    c_d[coef_addr] = coef_data;
                end
                if (in_valid && in_ready_q) begin
                    x_d     = {x_q[TAPS-2:0], in_data};
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (centre) begin
                    // Capture the final sum here so out_data and out_valid
                    // rise together on entry to DONE.
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = scale(acc_sum);
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_bc_fir_sym_serial.sv
// ---------------------------------------------------------------------------
// tb_bc_fir_sym_serial
//
// Scoreboard bench for bc_fir_sym_serial with default parameters. The driver
// pushes the expected output of each accepted sample. The monitors pop and
// compare data and accept-to-strobe latency whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_bc_fir_sym_serial;

    localparam int WIDTH  = 16;
    localparam int TAPS   = 39;
    localparam int COEF_W = 12;
    localparam int SHIFT  = 12;
    localparam int H      = (TAPS + 1) / 2;
    localparam int AW     = $clog2(H);
`ifdef BC_FIR_SAT_EN
    localparam longint OVF_EXP = 65535;
`else
    localparam longint OVF_EXP = 64873;
`endif

    logic              clock;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;

    int     tests;
    int     fails;
    int     cyc;
    bit     bp_mode;
    int     last_acc;
    longint exp_q[$];
    string  name_q[$];
    int     due_q[$];
    longint x_m[TAPS];
    longint c_m[H];

    int coef_set[H] = '{0, 0, 2, 0, 5, 0, 11, 0, 23, 0, 43, 0, 76, 0, 133, 0, 258, 0, 835, 1324};
    int imp_half[H] = '{0, 0, 1, 0, 4, 0, 10, 0, 22, 0, 42, 0, 75, 0, 132, 0, 257, 0, 834, 1323};

    bc_fir_sym_serial #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic longint model_y();
        longint acc;
        longint maxv;
        acc  = 0;
        maxv = (longint'(1) << WIDTH) - 1;
        for (int t = 0; t < TAPS; t++) begin
            int k;
            k = (t < H) ? t : (TAPS - 1 - t);
            acc += c_m[k] * x_m[t];
        end
        acc = acc >> SHIFT;
`ifdef BC_FIR_SAT_EN
        if (acc > maxv) acc = maxv;
`else
        acc = acc & maxv;
`endif
        return acc;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < TAPS; t++) x_m[t] = 0;
        for (int k = 0; k < H; k++) c_m[k] = 0;
    endtask

    task automatic model_push(input longint d, input string nm, input bit use_hand, input longint hand);
        for (int t = TAPS - 1; t > 0; t--) x_m[t] = x_m[t-1];
        x_m[0] = d;
        exp_q.push_back(use_hand ? hand : model_y());
        name_q.push_back(nm);
    endtask

    // Accept detector: records the edge on which out_valid must rise.
    task automatic acc_mon();
        forever begin
            @(posedge clock);
            cyc++;
            if (reset_n && in_valid && in_ready) begin
                due_q.push_back(cyc + H);
                if (bp_mode) begin
                    if (last_acc >= 0) check("bp_spacing", longint'(cyc - last_acc), H + 2);
                    last_acc = cyc;
                end
            end
        end
    endtask

    // Output monitor: pops the scoreboard on every strobe.
    task automatic out_mon();
        forever begin
            @(negedge clock);
            if (out_valid) begin
                if (due_q.size() == 0) check("unexpected_out_valid", longint'(out_valid), 0);
                else check("latency", longint'(cyc), longint'(due_q.pop_front()));
                if (exp_q.size() == 0) check("unexpected_out_data", longint'(out_valid), 0);
                else check(name_q.pop_front(), longint'(out_data), exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            fails++;
            $display("FAIL ready_timeout: in_ready=0 after %0d cycles, expected 1", n);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "in_ready timeout");
        end
    endtask

    task automatic send(input longint d, input string nm, input bit use_hand, input longint hand,
                        input bit we, input int wa, input int wd);
        wait_ready();
        if (we) begin
            coef_we   = 1'b1;
            coef_addr = AW'(wa);
            coef_data = COEF_W'(wd);
            if (wa < H) c_m[wa] = wd;
        end
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        model_push(d, nm, use_hand, hand);
        @(negedge clock);
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic write_idle(input int wa, input int wd);
        wait_ready();
        coef_we   = 1'b1;
        coef_addr = AW'(wa);
        coef_data = COEF_W'(wd);
        if (wa < H) c_m[wa] = wd;
        @(negedge clock);
        coef_we = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        bp_mode   = 1'b0;
        last_acc  = -1;
        model_clear();
        fork
            acc_mon();
            out_mon();
        join_none

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst_ready_first_clk", longint'(in_ready), 1);

        for (int k = 0; k < H; k++) write_idle(k, coef_set[k]);

        // Impulse on an empty line
        for (int i = 0; i < TAPS; i++)
            send((i == 0) ? 4095 : 0, "impulse", 1'b1,
                 imp_half[(i < H) ? i : (TAPS - 1 - i)], 1'b0, 0, 0);

        // DC gain; last output sees a full line of 1000
        for (int i = 0; i < TAPS; i++)
            send(1000, "dc", (i == TAPS - 1), 1000, 1'b0, 0, 0);

        // Coefficient write during MAC is dropped
        send(1000, "mac_write_cur", 1'b1, 1000, 1'b0, 0, 0);
        repeat (3) @(negedge clock);
        check("in_ready_in_mac", longint'(in_ready), 0);
        coef_we   = 1'b1;
        coef_addr = AW'(19);
        coef_data = '0;
        @(negedge clock);
        coef_we = 1'b0;
        send(1000, "mac_write_next", 1'b1, 1000, 1'b0, 0, 0);

        // Same write in IDLE takes effect; out-of-range address is dropped
        write_idle(19, 0);
        write_idle(25, 999);
        send(1000, "idle_write", 1'b1, 676, 1'b0, 0, 0);

        // Write and accept in the same cycle: new coefficient applies
        send(1000, "write_with_accept", 1'b1, 1000, 1'b1, 19, 1324);

        // Backpressure: in_valid held high across several samples
        bp_mode  = 1'b1;
        last_acc = -1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_ready();
            in_data = WIDTH'(100 * (i + 1));
            model_push(100 * (i + 1), "backpressure", 1'b0, 0);
        end
        @(negedge clock);
        in_valid = 1'b0;
        bp_mode  = 1'b0;

        // Overflow with all coefficients at maximum
        for (int k = 0; k < H; k++) write_idle(k, 4095);
        for (int i = 0; i < TAPS; i++)
            send(65535, "overflow", (i == TAPS - 1), OVF_EXP, 1'b0, 0, 0);

        // Reset in MAC cycle 5 aborts the sample
        wait_ready();
        in_valid = 1'b1;
        in_data  = WIDTH'(1234);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        due_q.delete();
        model_clear();
        #1;
        check("midmac_out_valid", longint'(out_valid), 0);
        check("midmac_out_data", longint'(out_data), 0);
        check("midmac_in_ready", longint'(in_ready), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("midmac_ready_first_clk", longint'(in_ready), 1);

        // Coefficients and delay line were cleared
        send(1000, "post_reset_coef0", 1'b1, 0, 1'b0, 0, 0);
        send(2000, "post_reset_coef0", 1'b1, 0, 1'b0, 0, 0);
        write_idle(19, 4095);
        send(500, "post_reset_line", 1'b1, 0, 1'b0, 0, 0);

        repeat (30) @(negedge clock);
        check("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
